// File: rtl/al_cpuregs_pkg.sv
// Shared types and helpers for the multi-read-port CPU register file.
package al_cpuregs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int PAR_MAX_W  = 64;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // Which value a read port presents: forced zero, storage, or the bypassed write.
    typedef enum logic [1:0] {SRC_ZERO, SRC_MEM, SRC_BYP} rd_src_t;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/al_cpuregs_bank.sv
// One-write / one-sync-read storage copy; the array has no reset so it maps to BRAM.
module al_cpuregs_bank #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/al_cpuregs_mp.sv
// Multi-read-port register file with post-reset self-clear, write-first bypass and zero register.
// Build option: CPUREGS_PARITY_EN adds a stored even-parity bit and the parity_err port.
module al_cpuregs_mp
    import al_cpuregs_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int NUM_RD       = 2,
    parameter int ZERO_REG     = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     ready
`ifdef CPUREGS_PARITY_EN
    ,
    output logic [NUM_RD-1:0]        parity_err
`endif
);

`ifdef CPUREGS_PARITY_EN
    localparam int BANK_W = DATA_W + 1;
`else
    localparam int BANK_W = DATA_W;
`endif

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                ready_q;
    logic                clearing;
    logic                zero_wr;
    logic                wr_ok;
    logic                bank_we;
    logic [ADDR_W-1:0]   bank_waddr;
    logic [BANK_W-1:0]   bank_wdata;

    assign ready      = ready_q;
    assign clearing   = (state_q == ST_CLEAR);
    assign zero_wr    = (ZERO_REG != 0) && (waddr == '0);
    assign wr_ok      = we && ready_q && !zero_wr;
    assign bank_we    = clearing || wr_ok;
    assign bank_waddr = clearing ? clr_cnt_q : waddr;

    // An all-zero word already carries correct even parity, so clearing writes '0.
`ifdef CPUREGS_PARITY_EN
    assign bank_wdata = clearing ? '0 : {even_par(PAR_MAX_W'(wdata)), wdata};
`else
    assign bank_wdata = clearing ? '0 : wdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN:  ready_q <= 1'b1;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              rd_ok;
        logic [BANK_W-1:0] bank_q;
        logic [DATA_W-1:0] byp_q;
        logic [DATA_W-1:0] rd_val;
        rd_src_t           src_q;

        assign ra    = raddr[i*ADDR_W +: ADDR_W];
        assign rd_ok = re[i] && ready_q;

        al_cpuregs_bank #(.DW(BANK_W), .AW(ADDR_W)) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (rd_ok),
            .raddr (ra),
            .rdata (bank_q)
        );

        // The bank register holds its word while re is low, so only the source select needs holding here.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                src_q <= SRC_ZERO;
                byp_q <= '0;
            end else if (rd_ok) begin
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    src_q <= SRC_ZERO;
                end else if (we && (waddr == ra)) begin
                    src_q <= SRC_BYP;
                    byp_q <= wdata;
                end else begin
                    src_q <= SRC_MEM;
                end
            end
        end

        always_comb begin
            rd_val = '0;
            case (src_q)
                SRC_MEM: rd_val = bank_q[DATA_W-1:0];
                SRC_BYP: rd_val = byp_q;
                default: rd_val = '0;
            endcase
        end

        assign rdata[i*DATA_W +: DATA_W] = rd_val;

`ifdef CPUREGS_PARITY_EN
        assign parity_err[i] = (src_q == SRC_MEM) &&
                               (even_par(PAR_MAX_W'(bank_q[DATA_W-1:0])) != bank_q[DATA_W]);
`endif
    end

endmodule

// File: tb/tb_al_cpuregs_mp.sv
// Self-checking bench for al_cpuregs_mp: vector table plus scoreboard queue and reset/clear sequences.
module tb_al_cpuregs_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [5:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  re = '0;
    logic [11:0] raddr = '0;
    logic [63:0] rdata;
    logic        ready;
`ifdef CPUREGS_PARITY_EN
    logic [1:0]  parity_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        perr;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  re;
        logic [5:0]  ra0;
        logic [5:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vecs[13];

    al_cpuregs_mp dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .ready      (ready)
`ifdef CPUREGS_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(name, rdata[e.port*32 +: 32], e.data);
`ifdef CPUREGS_PARITY_EN
            chk({name, "_perr"}, {31'd0, parity_err[e.port]}, {31'd0, e.perr});
`endif
        end
    endtask

    task automatic cycle(input string name, input logic w, input logic [5:0] wa, input logic [31:0] wd,
                         input logic [1:0] r, input logic [5:0] a0, input logic [5:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
        we    = w;
        waddr = wa;
        wdata = wd;
        re    = r;
        raddr = {a1, a0};
        sb_q.push_back('{0, e0, 1'b0});
        sb_q.push_back('{1, e1, 1'b0});
        step();
        drain(name);
        we = 1'b0;
        re = '0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
            if (!ready) chk({name, "_rdata_zero"}, rdata[31:0] | rdata[63:32], 32'd0);
        end
        chk({name, "_cycles"}, n, 32'd64);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 2'b00, 6'd0,  6'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 6'd0,  32'h0,        2'b11, 6'd5,  6'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 6'd7,  32'h12345678, 2'b01, 6'd7,  6'd0,  32'h12345678, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 6'd0,  32'h0,        2'b10, 6'd0,  6'd7,  32'h12345678, 32'h12345678};
        vecs[4]  = '{1'b1, 6'd0,  32'hFFFFFFFF, 2'b00, 6'd0,  6'd0,  32'h12345678, 32'h12345678};
        vecs[5]  = '{1'b0, 6'd0,  32'h0,        2'b11, 6'd0,  6'd0,  32'h0,        32'h0};
        vecs[6]  = '{1'b1, 6'd0,  32'hFFFFFFFF, 2'b01, 6'd0,  6'd0,  32'h0,        32'h0};
        vecs[7]  = '{1'b1, 6'd9,  32'hA5A5A5A5, 2'b11, 6'd9,  6'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 6'd5,  32'h11112222, 2'b10, 6'd0,  6'd5,  32'hA5A5A5A5, 32'h11112222};
        vecs[9]  = '{1'b0, 6'd0,  32'h0,        2'b11, 6'd5,  6'd9,  32'h11112222, 32'hA5A5A5A5};
        vecs[10] = '{1'b0, 6'd9,  32'hFFFF0000, 2'b11, 6'd9,  6'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 6'd63, 32'hCAFEF00D, 2'b00, 6'd0,  6'd0,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[12] = '{1'b0, 6'd0,  32'h0,        2'b11, 6'd63, 6'd62, 32'hCAFEF00D, 32'h0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rdata", rdata[31:0] | rdata[63:32], 32'd0);

        re    = 2'b11;
        raddr = {6'd20, 6'd10};
        rst   = 1'b0;
        wait_ready("clear1");
        re = '0;

        for (int a = 0; a < 64; a++)
            cycle("clear_read", 1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(63 - a), 32'h0, 32'h0);

        for (int i = 0; i < 13; i++)
            cycle($sformatf("vec%0d", i), vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re,
                  vecs[i].ra0, vecs[i].ra1, vecs[i].e0, vecs[i].e1);

        for (int i = 0; i < 10; i++)
            cycle("hold", 1'b1, 6'd63, 32'h5000_0000 + 32'(i), 2'b00, 6'd63, 6'd62,
                  32'hCAFEF00D, 32'h0);

        cycle("preclear_read", 1'b0, 6'd0, 32'h0, 2'b01, 6'd5, 6'd0, 32'h11112222, 32'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("midclear_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midclear_rst_ready", {31'd0, ready}, 32'd0);
        #1;
        rst = 1'b0;
        wait_ready("clear2");

        cycle("after_clear_63", 1'b0, 6'd0, 32'h0, 2'b11, 6'd63, 6'd5, 32'h0, 32'h0);
        cycle("after_clear_9",  1'b0, 6'd0, 32'h0, 2'b11, 6'd9,  6'd7, 32'h0, 32'h0);

`ifdef CPUREGS_PARITY_EN
        cycle("par_wr3", 1'b1, 6'd3, 32'h0000_0001, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        cycle("par_wr4", 1'b1, 6'd4, 32'h0000_0F0F, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        dut.g_rd[0].u_bank.mem_q[3][0] = ~dut.g_rd[0].u_bank.mem_q[3][0];
        re    = 2'b11;
        raddr = {6'd4, 6'd3};
        sb_q.push_back('{0, 32'h0, 1'b1});
        sb_q.push_back('{1, 32'h0000_0F0F, 1'b0});
        step();
        drain("parity");
        re = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/al_cpuregs_mp.md
Name: al_cpuregs_mp

Overview:
Parametrised multi-read-port CPU register file, successor to the single-read 64x32 BRAM register file.
- One write port and NUM_RD synchronous read ports (rs1/rs2 for the picorv32 core, more for debug).
- Write-to-read bypass and optional hardwired zero register.
- Self-clearing of all storage after reset, because BRAM contents cannot be reset.
- Sits between the core's decode/writeback stages and the BRAM-mapped storage.

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = address 0 reads 0 and writes to it are dropped
CLEAR_ON_RST, 1, 1 = zero every entry after reset before asserting ready

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W]
ready  out  1  high when the file accepts reads and writes
parity_err  out  NUM_RD  per-port parity error, aligned with rdata (CPUREGS_PARITY_EN only)

Behaviour:
- Reset (async assert): state=CLEAR (or RUN if CLEAR_ON_RST=0), clr_cnt=0, ready=0, rdata=0, parity_err=0. Storage array itself is not reset.
- FSM, two states:
  - CLEAR: each clk writes 0 (and correct parity) to address clr_cnt, then clr_cnt++. The cycle writing DEPTH-1 transitions to RUN. ready=1 from the next edge, so DEPTH cycles after rst release (64 by default).
  - RUN: normal operation; stays in RUN until rst.
  - CLEAR_ON_RST=0: RUN entered at the first edge after rst release; ready=1 there.
- Reset asserted mid-CLEAR or mid-RUN: immediately returns to the reset values and restarts the clear.
- While ready=0:
  - we and re are ignored.
  - rdata holds 0.
- Write: when we=1 and ready=1, wdata is stored at waddr on the clk edge. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read: latency 1.
  - When re[i]=1 and ready=1, rdata[i] takes mem[raddr[i]] at the edge.
  - When re[i]=0, rdata[i] holds its previous value.
- Bypass (write-first): same-cycle we=1, re[i]=1, waddr==raddr[i] -> rdata[i]=wdata. Does not apply when ZERO_REG=1 and address is 0.
- ZERO_REG=1, raddr[i]=0, re[i]=1 -> rdata[i]=0, regardless of storage or bypass.
- All read ports are independent. Identical addresses on several ports return identical data the same cycle.
- Storage: one copy per read port, every copy written by the write port, so each copy maps to a simple dual-port BRAM.

Optional Feature:
CPUREGS_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit (^wdata).
  - On a read from storage, parity_err[i] is registered with rdata[i] and is 1 on mismatch.
  - Bypassed reads and zero-register reads give parity_err=0.
  - CLEAR writes valid parity.
- Undefined: no parity bit is stored, and the parity_err port is absent.

Decomposition:
- Package al_cpuregs_pkg holds:
  - default DATA_W/ADDR_W constants
  - the state enum {ST_CLEAR, ST_RUN}
  - the parity function
- Sub-module al_cpuregs_bank: one write / one sync-read memory of DEPTH x (DATA_W+parity), with no reset on the array. It is instantiated NUM_RD times.
- Top level holds the FSM, clear counter, bypass/zero muxes and output registers.

Test Plan:
- Release rst, hold re=1 on all ports -> ready=0 for exactly 64 cycles, then ready=1; reads of every address return 0x00000000.
- Write 0xDEADBEEF to addr 5, then next cycle read addr 5 on port 0 and port 1 -> both rdata=0xDEADBEEF one cycle later.
- Same cycle: we=1, waddr=7, wdata=0x12345678, re[0]=1, raddr[0]=7 -> rdata[0]=0x12345678 next cycle; port 1 reading addr 7 a cycle later also returns 0x12345678.
- Write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0 (ZERO_REG=1); same-cycle bypass at addr 0 also returns 0.
- Assert rst at clear cycle 30, release -> a full 64-cycle clear restarts. re=0 holds the previous rdata value across 10 cycles.
- CPUREGS_PARITY_EN: force-flip one stored bit at addr 3 via hierarchical deposit, read addr 3 -> parity_err[0]=1 with rdata. Addr 4 read -> parity_err=0.
